// File: rtl/ysyx_22050854_regfile_sb_if.sv
// ysyx_22050854_regfile_sb_if
//   Bus bundle for the register file / scoreboard.
//   master : issue/writeback/debug side (drives addresses, data, enables)
//   slave  : the register file (drives read data, busy, ready, error)
//   Signals:
//     w0_*      write port 0 (ALU writeback)
//     w1_*      write port 1 (LSU writeback, wins on same address)
//     r_addr    packed read addresses, port i at [i*AW +: AW]
//     r_data    packed read data, port i at [i*XLEN +: XLEN]
//     r_busy    per read port: source register has a pending write
//     iss_*     destination reservation request / acceptance
//     sb_err    sticky scoreboard overflow/underflow flag
//     dbg_*     unbypassed debug read port
interface ysyx_22050854_regfile_sb_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5,
  parameter int unsigned NR   = 2
);
  logic               w0_en;
  logic [AW-1:0]      w0_addr;
  logic [XLEN-1:0]    w0_data;
  logic               w1_en;
  logic [AW-1:0]      w1_addr;
  logic [XLEN-1:0]    w1_data;
  logic [NR*AW-1:0]   r_addr;
  logic [NR*XLEN-1:0] r_data;
  logic [NR-1:0]      r_busy;
  logic               iss_en;
  logic [AW-1:0]      iss_addr;
  logic               iss_ready;
  logic               sb_err;
  logic [AW-1:0]      dbg_addr;
  logic [XLEN-1:0]    dbg_data;

  modport master (
    output w0_en, w0_addr, w0_data,
    output w1_en, w1_addr, w1_data,
    output r_addr, iss_en, iss_addr, dbg_addr,
    input  r_data, r_busy, iss_ready, sb_err, dbg_data
  );

  modport slave (
    input  w0_en, w0_addr, w0_data,
    input  w1_en, w1_addr, w1_data,
    input  r_addr, iss_en, iss_addr, dbg_addr,
    output r_data, r_busy, iss_ready, sb_err, dbg_data
  );
endinterface

// File: rtl/ysyx_22050854_regfile_sb.sv
// ysyx_22050854_regfile_sb
//   Multi-read, dual-write integer register file with a per-register
//   pending-write counter (scoreboard). x0 reads as zero and is never
//   written or tracked.
//   Ports:
//     clk    clock, all state updates on posedge
//     rst_n  asynchronous active-low reset, clears data, counters, sb_err
//     bus    ysyx_22050854_regfile_sb_if slave modport (read/write/issue/debug)
module ysyx_22050854_regfile_sb #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned AW     = 5,
  parameter int unsigned NR     = 2,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned CW     = 2
) (
  input logic                        clk,
  input logic                        rst_n,
  ysyx_22050854_regfile_sb_if.slave  bus
);
  localparam int unsigned NREG = 1 << AW;
  localparam logic [CW-1:0] CMAX = '1;

  logic [XLEN-1:0] r_rf  [NREG];
  logic [CW-1:0]   r_cnt [NREG];
  logic            r_err;

  logic [1:0]      w_dec     [NREG];
  logic [CW-1:0]   w_cnt_nxt [NREG];
  logic [CW:0]     w_sum;
  logic            w_inc;
  logic            w_under;
  logic            w_iss_wr;
  logic            w_iss_ready;
  logic            w_err_set;
  logic [AW-1:0]   w_ra;
  logic [XLEN-1:0] w_rd;

  // Number of writebacks landing on each register this cycle (0..2).
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      w_dec[r] = 2'(bus.w0_en && (bus.w0_addr == AW'(r)))
               + 2'(bus.w1_en && (bus.w1_addr == AW'(r)));
    end
  end

  // A saturated counter can still accept a reservation when a writeback
  // to the same register retires one in the same cycle.
  always_comb begin
    w_iss_wr    = (bus.w0_en && (bus.w0_addr == bus.iss_addr))
               || (bus.w1_en && (bus.w1_addr == bus.iss_addr));
    w_iss_ready = (bus.iss_addr == '0) || (r_cnt[bus.iss_addr] != CMAX) || w_iss_wr;
  end

  always_comb begin
    w_under      = 1'b0;
    w_inc        = 1'b0;
    w_sum        = '0;
    w_cnt_nxt[0] = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      w_inc = bus.iss_en && w_iss_ready && (bus.iss_addr == AW'(r));
      w_sum = {1'b0, r_cnt[r]} + (CW+1)'(w_inc);
      if ((CW+1)'(w_dec[r]) > w_sum) begin
        w_cnt_nxt[r] = '0;
        w_under      = 1'b1;
      end else begin
        w_cnt_nxt[r] = CW'(w_sum - (CW+1)'(w_dec[r]));
      end
    end
    w_err_set = w_under || (bus.iss_en && !w_iss_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        r_rf[r]  <= '0;
        r_cnt[r] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      if (bus.w0_en && (bus.w0_addr != '0)) r_rf[bus.w0_addr] <= bus.w0_data;
      // Port 1 assigned last so it wins an address collision.
      if (bus.w1_en && (bus.w1_addr != '0)) r_rf[bus.w1_addr] <= bus.w1_data;
      for (int unsigned r = 1; r < NREG; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Busy with bypass compares against the writebacks retiring this cycle,
  // clamped at zero so an underflowing write never reads as busy.
  always_comb begin
    bus.r_data = '0;
    bus.r_busy = '0;
    w_ra       = '0;
    w_rd       = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      w_ra = bus.r_addr[i*AW +: AW];
      if (w_ra != '0) begin
        w_rd = r_rf[w_ra];
        if ((BYPASS != 0) && bus.w0_en && (bus.w0_addr == w_ra)) w_rd = bus.w0_data;
        if ((BYPASS != 0) && bus.w1_en && (bus.w1_addr == w_ra)) w_rd = bus.w1_data;
        bus.r_data[i*XLEN +: XLEN] = w_rd;
        if (BYPASS != 0) bus.r_busy[i] = {1'b0, r_cnt[w_ra]} > (CW+1)'(w_dec[w_ra]);
        else             bus.r_busy[i] = r_cnt[w_ra] != '0;
      end
    end
  end

  assign bus.dbg_data  = r_rf[bus.dbg_addr];
  assign bus.iss_ready = w_iss_ready;
  assign bus.sb_err    = r_err;
endmodule

// File: tb/tb_ysyx_22050854_regfile_sb.sv
module tb_ysyx_22050854_regfile_sb;
  logic clk;
  logic rst_n;

  ysyx_22050854_regfile_sb_if #(.XLEN(64), .AW(5), .NR(2)) ifa ();
  ysyx_22050854_regfile_sb_if #(.XLEN(64), .AW(5), .NR(2)) ifb ();

  // DUT a: bypass enabled. DUT b: no bypass, same stimulus.
  ysyx_22050854_regfile_sb #(.XLEN(64), .AW(5), .NR(2), .BYPASS(1), .CW(2)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  ysyx_22050854_regfile_sb #(.XLEN(64), .AW(5), .NR(2), .BYPASS(0), .CW(2)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  assign ifb.w0_en    = ifa.w0_en;
  assign ifb.w0_addr  = ifa.w0_addr;
  assign ifb.w0_data  = ifa.w0_data;
  assign ifb.w1_en    = ifa.w1_en;
  assign ifb.w1_addr  = ifa.w1_addr;
  assign ifb.w1_data  = ifa.w1_data;
  assign ifb.r_addr   = ifa.r_addr;
  assign ifb.iss_en   = ifa.iss_en;
  assign ifb.iss_addr = ifa.iss_addr;
  assign ifb.dbg_addr = ifa.dbg_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic expect_v(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.w0_en  = 1'b0;
    ifa.w1_en  = 1'b0;
    ifa.iss_en = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b1;
    ifa.w0_en    = 1'b0; ifa.w0_addr = '0; ifa.w0_data = '0;
    ifa.w1_en    = 1'b0; ifa.w1_addr = '0; ifa.w1_data = '0;
    ifa.r_addr   = {5'd2, 5'd1};
    ifa.iss_en   = 1'b0; ifa.iss_addr = '0;
    ifa.dbg_addr = 5'd17;
    #2 rst_n = 1'b0;
    expect_v("rst0_iss_ready", 64'd1);
    expect_v("rst0_sb_err", 64'd0);
    expect_v("rst0_rdata", 64'd0);
    #1;
    chk(64'(ifa.iss_ready));
    chk(64'(ifa.sb_err));
    chk(ifa.r_data[63:0]);
    #2 rst_n = 1'b1;

    // Fill x1..x31 without reservations (each write underflows).
    for (int i = 1; i < 32; i++) begin
      ifa.w0_en = 1'b1; ifa.w0_addr = 5'(i); ifa.w0_data = 64'h1000 + 64'(i);
      tick();
    end
    idle();
    expect_v("fill_dbg_x17", 64'h1011);
    expect_v("fill_sb_err", 64'd1);
    expect_v("fill_rdata1_x2", 64'h1002);
    #1;
    chk(ifa.dbg_data);
    chk(64'(ifa.sb_err));
    chk(ifa.r_data[127:64]);

    // Asynchronous reset pulse between edges.
    rst_n = 1'b0;
    expect_v("rst_dbg", 64'd0);
    expect_v("rst_rdata", 64'd0);
    expect_v("rst_busy", 64'd0);
    expect_v("rst_iss_ready", 64'd1);
    expect_v("rst_sb_err", 64'd0);
    #1;
    chk(ifa.dbg_data);
    chk(64'(ifa.r_data));
    chk(64'(ifa.r_busy));
    chk(64'(ifa.iss_ready));
    chk(64'(ifa.sb_err));
    #1 rst_n = 1'b1;
    tick();

    // x0: write and issue are ignored.
    ifa.w0_en = 1'b1; ifa.w0_addr = 5'd0; ifa.w0_data = 64'hFFFF;
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd0;
    ifa.r_addr = {5'd0, 5'd0}; ifa.dbg_addr = 5'd0;
    expect_v("x0_rdata_byp", 64'd0);
    expect_v("x0_iss_ready", 64'd1);
    #1;
    chk(ifa.r_data[63:0]);
    chk(64'(ifa.iss_ready));
    tick();
    idle();
    expect_v("x0_busy", 64'd0);
    expect_v("x0_dbg", 64'd0);
    expect_v("x0_sb_err", 64'd0);
    #1;
    chk(64'(ifa.r_busy));
    chk(ifa.dbg_data);
    chk(64'(ifa.sb_err));

    // Bypass on x7: reserve twice, write 0x77, then 0x1234 while reading.
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd7;
    tick(); tick();
    idle();
    ifa.w0_en = 1'b1; ifa.w0_addr = 5'd7; ifa.w0_data = 64'h77;
    tick();
    ifa.w0_data = 64'h1234; ifa.r_addr = {5'd0, 5'd7}; ifa.dbg_addr = 5'd7;
    expect_v("byp_a_rdata", 64'h1234);
    expect_v("byp_b_rdata", 64'h77);
    expect_v("byp_a_busy", 64'd0);
    expect_v("byp_b_busy", 64'd1);
    #1;
    chk(ifa.r_data[63:0]);
    chk(ifb.r_data[63:0]);
    chk(64'(ifa.r_busy[0]));
    chk(64'(ifb.r_busy[0]));
    tick();
    idle();
    expect_v("byp_b_next", 64'h1234);
    expect_v("byp_dbg_next", 64'h1234);
    expect_v("byp_sb_err", 64'd0);
    #1;
    chk(ifb.r_data[63:0]);
    chk(ifa.dbg_data);
    chk(64'(ifa.sb_err));

    // Write-port collision on x5 with one reservation: w1 wins, underflow.
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd5;
    tick();
    idle();
    ifa.w0_en = 1'b1; ifa.w0_addr = 5'd5; ifa.w0_data = 64'hAAAA;
    ifa.w1_en = 1'b1; ifa.w1_addr = 5'd5; ifa.w1_data = 64'h5555;
    ifa.r_addr = {5'd5, 5'd0}; ifa.dbg_addr = 5'd5;
    expect_v("col_a_rdata1", 64'h5555);
    expect_v("col_a_busy1", 64'd0);
    #1;
    chk(ifa.r_data[127:64]);
    chk(64'(ifa.r_busy[1]));
    tick();
    idle();
    expect_v("col_dbg", 64'h5555);
    expect_v("col_sb_err", 64'd1);
    expect_v("col_b_busy1", 64'd0);
    #1;
    chk(ifa.dbg_data);
    chk(64'(ifa.sb_err));
    chk(64'(ifb.r_busy[1]));

    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    tick();

    // Scoreboard saturation on x3.
    ifa.r_addr = {5'd0, 5'd3}; ifa.dbg_addr = 5'd3;
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd3;
    expect_v("sb_first_ready", 64'd1);
    expect_v("sb_issue_cycle_busy", 64'd0);
    #1;
    chk(64'(ifa.iss_ready));
    chk(64'(ifa.r_busy[0]));
    tick(); tick(); tick();
    ifa.iss_en = 1'b0;
    expect_v("sb_sat_busy", 64'd1);
    expect_v("sb_sat_ready", 64'd0);
    expect_v("sb_sat_err", 64'd0);
    #1;
    chk(64'(ifa.r_busy[0]));
    chk(64'(ifa.iss_ready));
    chk(64'(ifa.sb_err));
    ifa.iss_en = 1'b1;
    tick();
    ifa.iss_en = 1'b0;
    expect_v("sb_ovf_err", 64'd1);
    expect_v("sb_ovf_ready", 64'd0);
    #1;
    chk(64'(ifa.sb_err));
    chk(64'(ifa.iss_ready));
    ifa.w0_en = 1'b1; ifa.w0_addr = 5'd3; ifa.w0_data = 64'h31;
    expect_v("sb_wb1_ready", 64'd1);
    expect_v("sb_wb1_busy", 64'd1);
    #1;
    chk(64'(ifa.iss_ready));
    chk(64'(ifa.r_busy[0]));
    tick();
    ifa.w0_data = 64'h32;
    tick();
    ifa.w0_en = 1'b0;
    ifa.w1_en = 1'b1; ifa.w1_addr = 5'd3; ifa.w1_data = 64'h33;
    expect_v("sb_wb3_a_busy", 64'd0);
    expect_v("sb_wb3_b_busy", 64'd1);
    #1;
    chk(64'(ifa.r_busy[0]));
    chk(64'(ifb.r_busy[0]));
    tick();
    idle();
    expect_v("sb_done_b_busy", 64'd0);
    expect_v("sb_done_dbg", 64'h33);
    expect_v("sb_done_ready", 64'd1);
    #1;
    chk(64'(ifb.r_busy[0]));
    chk(ifa.dbg_data);
    chk(64'(ifa.iss_ready));

    // Simultaneous issue and writeback on x9 with count 1.
    ifa.r_addr = {5'd0, 5'd9}; ifa.dbg_addr = 5'd9;
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd9;
    tick();
    ifa.w1_en = 1'b1; ifa.w1_addr = 5'd9; ifa.w1_data = 64'h99;
    expect_v("x9_same_ready", 64'd1);
    #1;
    chk(64'(ifa.iss_ready));
    tick();
    idle();
    expect_v("x9_a_busy", 64'd1);
    expect_v("x9_b_busy", 64'd1);
    expect_v("x9_dbg", 64'h99);
    #1;
    chk(64'(ifa.r_busy[0]));
    chk(64'(ifb.r_busy[0]));
    chk(ifa.dbg_data);
    ifa.w0_en = 1'b1; ifa.w0_addr = 5'd9; ifa.w0_data = 64'h9A;
    expect_v("x9_wb_a_busy", 64'd0);
    expect_v("x9_wb_a_rdata", 64'h9A);
    #1;
    chk(64'(ifa.r_busy[0]));
    chk(ifa.r_data[63:0]);
    tick();
    idle();
    expect_v("x9_end_b_busy", 64'd0);
    expect_v("x9_end_dbg", 64'h9A);
    #1;
    chk(64'(ifb.r_busy[0]));
    chk(ifa.dbg_data);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
